grid_io_param: RTL and testbench
================================

Name: grid_io_param

Overview:
- Parametrised IO grid tile with N_PADS pad subtiles, each configured by a 4-bit word loaded through the tile's configuration chain.
- Sits on the fabric perimeter between the routing channel (fabric side) and the GPIO pads (pad side).
- Adds per-pad direction modes, optional input/output registers, a bidirectional mode with fabric-driven output enable, and a configuration-length checker.
- All pads are held safe (high-Z, fabric inputs 0) until a complete configuration has been loaded.

Parameters:
- N_PADS, 8, number of pad subtiles (1..32).
- Derived localparams (not overridable): CFG_BITS = 4; CHAIN_LEN = N_PADS*CFG_BITS; CNT_W = clog2(CHAIN_LEN+1).

Ports:
- prog_clk  input  1  single clock; drives configuration shifting and the IO registers.
- pReset  input  1  reset, asynchronous, active-low.
- ccff_en  input  1  shift enable for the configuration chain.
- ccff_head  input  1  serial configuration data in.
- ccff_tail  output  1  serial configuration data out (last chain bit).
- cfg_done  output  1  high when a complete, correct-length configuration is active.
- cfg_err  output  1  sticky flag: a shift session ended with the wrong bit count.
- fabric_outpad  input  N_PADS  data from fabric toward pads.
- fabric_oe  input  N_PADS  fabric output enable, used in bidir mode only.
- fabric_inpad  output  N_PADS  data from pads toward fabric.
- pad_i  input  N_PADS  pad receive data.
- pad_o  output  N_PADS  pad drive data.
- pad_oe  output  N_PADS  pad driver enable (1 = drive).

Behaviour:
- Chain: on a rising edge with ccff_en=1: chain[0]<=ccff_head, chain[i]<=chain[i-1]; ccff_tail=chain[CHAIN_LEN-1].
- Pad k word is chain[4k+3:4k]:
  - [1:0] mode: 00 off, 01 in, 10 out, 11 bidir.
  - [2] ireg_en.
  - [3] oreg_en.
- First bit shifted ends at chain[CHAIN_LEN-1], which is pad N_PADS-1 bit 3.
- FSM states UNCFG, SHIFT, DONE; counter cnt (CNT_W bits).
  - UNCFG: ccff_en=1 -> SHIFT, cnt=1.
  - SHIFT: ccff_en=1 -> cnt+1, saturating at CHAIN_LEN+1 (marks overrun). ccff_en=0 -> DONE if cnt==CHAIN_LEN, else UNCFG with cfg_err<=1.
  - DONE: ccff_en=1 -> SHIFT, cnt=1. The old configuration is deactivated on that same edge.
- cfg_done = (state==DONE), registered. cfg_err clears only on reset.
- Outside DONE: pad_oe=0, pad_o=0, fabric_inpad=0, and the IO registers are held at 0.
- In DONE, per pad:
  - off: oe=0, inpad=0.
  - in: oe=0; inpad = ireg_en ? in_q : pad_i.
  - out: oe=1; pad_o = oreg_en ? out_q : fabric_outpad; inpad=0.
  - bidir: pad_o and inpad as for out/in; oe = oreg_en ? oe_q : fabric_oe.
- IO registers in_q, out_q, oe_q sample every edge while in DONE. Latency is 1 cycle when the register is enabled, 0 (combinational) when bypassed.
- Reset (async, any time, including mid-shift): chain=0, state=UNCFG, cnt=0, all registers 0, cfg_done=0, cfg_err=0. Outputs become 0 immediately on reset assertion.
- Simultaneous ccff_en=1 with fabric traffic in DONE: the state leaves DONE on that edge, so the pads go high-Z from that edge onward.

Optional Feature:
- Macro GRID_IO_PARAM_SYNC_IN_EN.
- Defined: pad_i passes through a 2-flop synchroniser (reset 0) before the mode/ireg logic. Input latency becomes 2 cycles (bypassed) or 3 cycles (ireg_en=1). The synchroniser flops run in all states.
- Undefined: pad_i is used directly; latencies as stated in Behaviour.

Test Plan:
- Reset, then shift 32 bits with pad0=4'b0010 (out) and all others 0, then drop ccff_en -> cfg_done=1 on the next edge; pad_oe=8'h01; pad_o[0] follows fabric_outpad[0] combinationally.
- Configure pad3=4'b0101 (in, ireg) and drive pad_i[3] 0->1 -> fabric_inpad[3] rises exactly 1 edge later; the other fabric_inpad bits stay 0.
- Configure pad5=4'b1011 (bidir, oreg); fabric_oe[5]=1, fabric_outpad[5]=1 -> pad_oe[5]=1 and pad_o[5]=1 one edge later; fabric_oe[5]=0 -> pad_oe[5]=0 one edge later.
- Shift 31 bits then drop ccff_en -> cfg_err=1, cfg_done=0, pad_oe=0. Repeat with 33 bits -> cfg_err stays 1, cfg_done=0.
- From DONE with pad0 out, raise ccff_en -> pad_oe=0 on that edge. Shift 32 bits again -> ccff_tail emits the previous word bits MSB-first.
- Assert pReset mid-shift (cnt=17) -> chain, cnt, and all outputs go to 0 asynchronously; the next session needs a full 32 bits to reach DONE.

Source files
------------

// File: rtl/grid_io_param.sv
// grid_io_param -- parametrised IO grid tile on the fabric perimeter.
//
// N_PADS pad subtiles, each configured by a 4-bit word taken from a serial
// configuration chain. All pads stay safe (not driven, fabric inputs 0)
// until a configuration of exactly CHAIN_LEN bits has been loaded.
//
// Pad word k = chain[4k+3:4k]: [1:0] mode (00 off, 01 in, 10 out, 11 bidir),
// [2] ireg_en, [3] oreg_en.
//
// Ports:
//   prog_clk       clock for configuration shifting and IO registers
//   pReset         asynchronous active-low reset
//   ccff_en        chain shift enable
//   ccff_head      serial configuration in
//   ccff_tail      serial configuration out (last chain bit)
//   cfg_done       complete, correct-length configuration is active
//   cfg_err        sticky: a shift session ended with the wrong bit count
//   fabric_outpad  fabric -> pad data
//   fabric_oe      fabric output enable (bidir mode)
//   fabric_inpad   pad -> fabric data
//   pad_i          pad receive data
//   pad_o          pad drive data
//   pad_oe         pad driver enable (1 = drive)
//
// Optional macro GRID_IO_PARAM_SYNC_IN_EN: pad_i passes through a 2-flop
// synchroniser before the input path.
//
// state | meaning
// UNCFG | no valid configuration, pads safe
// SHIFT | shift session in progress, counting bits
// DONE  | configuration active, pads operate per mode

module grid_io_param #(
   parameter int N_PADS = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              ccff_en,
   input  logic              ccff_head,
   output logic              ccff_tail,
   output logic              cfg_done,
   output logic              cfg_err,
   input  logic [N_PADS-1:0] fabric_outpad,
   input  logic [N_PADS-1:0] fabric_oe,
   output logic [N_PADS-1:0] fabric_inpad,
   input  logic [N_PADS-1:0] pad_i,
   output logic [N_PADS-1:0] pad_o,
   output logic [N_PADS-1:0] pad_oe
);

   localparam int CFG_BITS  = 4;
   localparam int CHAIN_LEN = N_PADS * CFG_BITS;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CHAIN_LEN + 1);

   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  err_set;
   logic [CHAIN_LEN-1:0]  chain;
   logic [N_PADS-1:0]     pad_in;
   logic [N_PADS-1:0]     in_q, out_q, oe_q;
   logic                  active;
   logic [CFG_BITS-1:0]   word;

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         chain <= '0;
      end else if (ccff_en) begin
         chain <= {chain[CHAIN_LEN-2:0], ccff_head};
      end
   end

   assign ccff_tail = chain[CHAIN_LEN-1];

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         state   <= UNCFG;
         cnt     <= '0;
         cfg_err <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (err_set) begin
            cfg_err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_set   = 1'b0;
      case (state)
         UNCFG: begin
            if (ccff_en) begin
               state_nxt = SHIFT;
               cnt_nxt   = CNT_ONE;
            end
         end
         SHIFT: begin
            if (ccff_en) begin
               // saturate one past full so an overrun can never wrap back to a legal count
               if (cnt != CNT_OVER) begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else if (cnt == CNT_FULL) begin
               state_nxt = DONE;
            end else begin
               state_nxt = UNCFG;
               cnt_nxt   = '0;
               err_set   = 1'b1;
            end
         end
         DONE: begin
            if (ccff_en) begin
               state_nxt = SHIFT;
               cnt_nxt   = CNT_ONE;
            end
         end
         default: begin
            state_nxt = UNCFG;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign active   = (state == DONE);
   assign cfg_done = active;

`ifdef GRID_IO_PARAM_SYNC_IN_EN
   logic [N_PADS-1:0] sync1, sync2;

   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pad_i;
         sync2 <= sync1;
      end
   end

   assign pad_in = sync2;
`else
   assign pad_in = pad_i;
`endif

   // IO registers are cleared whenever the tile is not configured so a new
   // configuration never sees stale data on its first active cycle.
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         in_q  <= '0;
         out_q <= '0;
         oe_q  <= '0;
      end else if (active) begin
         in_q  <= pad_in;
         out_q <= fabric_outpad;
         oe_q  <= fabric_oe;
      end else begin
         in_q  <= '0;
         out_q <= '0;
         oe_q  <= '0;
      end
   end

   always_comb begin
      pad_o        = '0;
      pad_oe       = '0;
      fabric_inpad = '0;
      word         = '0;
      for (int k = 0; k < N_PADS; k++) begin
         word = chain[CFG_BITS*k +: CFG_BITS];
         if (active) begin
            case (word[1:0])
               2'b01: begin
                  fabric_inpad[k] = word[2] ? in_q[k] : pad_in[k];
               end
               2'b10: begin
                  pad_oe[k] = 1'b1;
                  pad_o[k]  = word[3] ? out_q[k] : fabric_outpad[k];
               end
               2'b11: begin
                  fabric_inpad[k] = word[2] ? in_q[k] : pad_in[k];
                  pad_o[k]        = word[3] ? out_q[k] : fabric_outpad[k];
                  pad_oe[k]       = word[3] ? oe_q[k] : fabric_oe[k];
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_grid_io_param.sv
// Testbench for grid_io_param (N_PADS = 8). Reference model keeps the chain
// as a FIFO of shifted bits and the configuration state as a session bit
// count; every cycle all outputs are compared against it, plus directed
// checks for the listed scenarios.

module tb_grid_io_param;

   localparam int N  = 8;
   localparam int CL = N * 4;
`ifdef GRID_IO_PARAM_SYNC_IN_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif
   localparam int IN_LAT = SYNC ? 3 : 1;

   logic          prog_clk = 1'b0;
   logic          pReset;
   logic          ccff_en, ccff_head;
   logic          ccff_tail, cfg_done, cfg_err;
   logic [N-1:0]  fabric_outpad, fabric_oe, fabric_inpad;
   logic [N-1:0]  pad_i, pad_o, pad_oe;

   grid_io_param #(.N_PADS(N)) dut (
      .prog_clk      (prog_clk),
      .pReset        (pReset),
      .ccff_en       (ccff_en),
      .ccff_head     (ccff_head),
      .ccff_tail     (ccff_tail),
      .cfg_done      (cfg_done),
      .cfg_err       (cfg_err),
      .fabric_outpad (fabric_outpad),
      .fabric_oe     (fabric_oe),
      .fabric_inpad  (fabric_inpad),
      .pad_i         (pad_i),
      .pad_o         (pad_o),
      .pad_oe        (pad_oe)
   );

   always #5 prog_clk = ~prog_clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model
   bit           m_q[$];      // m_q[0] is the oldest bit, i.e. the tail
   bit           m_active, m_shift, m_err;
   int           m_cnt;
   logic [N-1:0] m_in_q, m_out_q, m_oe_q, m_s1, m_s2;
   bit           rand_io;

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < CL; i++) m_q.push_back(1'b0);
      m_active = 0; m_shift = 0; m_err = 0; m_cnt = 0;
      m_in_q = '0; m_out_q = '0; m_oe_q = '0; m_s1 = '0; m_s2 = '0;
   endtask

   function automatic logic [3:0] m_word(input int k);
      logic [3:0] w;
      for (int b = 0; b < 4; b++) w[b] = m_q[CL-1-4*k-b];
      return w;
   endfunction

   task automatic check_outputs();
      logic [N-1:0] eo, eoe, ei, pe;
      logic [3:0]   w;
      eo = '0; eoe = '0; ei = '0;
      pe = SYNC ? m_s2 : pad_i;
      if (m_active) begin
         for (int k = 0; k < N; k++) begin
            w = m_word(k);
            if (w[0]) ei[k] = w[2] ? m_in_q[k] : pe[k];
            if (w[1]) eo[k] = w[3] ? m_out_q[k] : fabric_outpad[k];
            if (w[1:0] == 2'b10) eoe[k] = 1'b1;
            if (w[1:0] == 2'b11) eoe[k] = w[3] ? m_oe_q[k] : fabric_oe[k];
         end
      end
      check("pad_oe", pad_oe, eoe);
      check("pad_o", pad_o, eo);
      check("fabric_inpad", fabric_inpad, ei);
      check("cfg_done", cfg_done, m_active);
      check("cfg_err", cfg_err, m_err);
      check("ccff_tail", ccff_tail, m_q[0]);
   endtask

   task automatic model_clock();
      logic [N-1:0] pe;
      pe = SYNC ? m_s2 : pad_i;
      if (m_active) begin
         m_in_q = pe; m_out_q = fabric_outpad; m_oe_q = fabric_oe;
      end else begin
         m_in_q = '0; m_out_q = '0; m_oe_q = '0;
      end
      m_s2 = m_s1;
      m_s1 = pad_i;
      if (ccff_en) begin
         void'(m_q.pop_front());
         m_q.push_back(ccff_head);
         if (!m_shift) begin
            m_shift = 1; m_cnt = 1; m_active = 0;
         end else begin
            m_cnt++;
         end
      end else if (m_shift) begin
         m_shift = 0;
         if (m_cnt == CL) m_active = 1;
         else m_err = 1;
      end
   endtask

   // one cycle: drive, check pre-edge outputs, clock, update model
   task automatic step(input bit en, input bit head);
      ccff_en   = en;
      ccff_head = head;
      if (rand_io) begin
         fabric_outpad = N'($urandom);
         fabric_oe     = N'($urandom);
         pad_i         = N'($urandom);
      end
      #1 check_outputs();
      @(posedge prog_clk);
      model_clock();
      #1;
   endtask

   // shift nbits, MSB first, so cfg[CL-1] lands at the far end of the chain
   task automatic load(input logic [CL-1:0] cfg, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) step(1'b1, (i < CL) ? cfg[i] : 1'b0);
      step(1'b0, 1'b0);
   endtask

   logic [CL-1:0] prev_cfg, new_cfg;
   int            nb;

   initial begin
      pReset = 1'b0; ccff_en = 0; ccff_head = 0;
      fabric_outpad = '0; fabric_oe = '0; pad_i = '0;
      rand_io = 0;
      model_reset();
      #1;
      check("rst_done", cfg_done, 0);
      check("rst_err", cfg_err, 0);
      check("rst_oe", pad_oe, 0);
      check("rst_tail", ccff_tail, 0);
      #11 pReset = 1'b1;
      @(posedge prog_clk); #1;

      // pad0 out, bypassed
      load(CL'(32'h2), CL);
      check("t1_done", cfg_done, 1);
      check("t1_oe", pad_oe, 8'h01);
      fabric_outpad = 8'h01;
      #1 check("t1_o_hi", pad_o[0], 1);
      fabric_outpad = 8'h00;
      #1 check("t1_o_lo", pad_o[0], 0);
      step(0, 0);

      // pad3 in, registered
      load(CL'(32'h5) << 12, CL);
      pad_i = '0;
      repeat (3) step(0, 0);
      pad_i[3] = 1'b1;
      for (int c = 1; c <= IN_LAT; c++) begin
         step(0, 0);
         check("t2_lat", fabric_inpad[3], (c == IN_LAT));
         check("t2_other", fabric_inpad & 8'hF7, 0);
      end
      pad_i = '0;

      // pad5 bidir, output registered
      load(CL'(32'hB) << 20, CL);
      fabric_oe = 8'h20; fabric_outpad = 8'h20;
      #1 check("t3_oe_pre", pad_oe[5], 0);
      step(0, 0);
      check("t3_oe_hi", pad_oe[5], 1);
      check("t3_o_hi", pad_o[5], 1);
      fabric_oe = 8'h00;
      step(0, 0);
      check("t3_oe_lo", pad_oe[5], 0);
      fabric_outpad = '0;

      // wrong lengths
      load(CL'(32'h2), CL - 1);
      check("t4_err31", cfg_err, 1);
      check("t4_done31", cfg_done, 0);
      check("t4_oe31", pad_oe, 0);
      load(CL'(32'h2), CL + 1);
      check("t4_err33", cfg_err, 1);
      check("t4_done33", cfg_done, 0);

      // reconfigure from DONE; tail replays the old word MSB first
      prev_cfg = CL'(32'h2);
      load(prev_cfg, CL);
      check("t5_done", cfg_done, 1);
      new_cfg = CL'($urandom);
      for (int i = 0; i < CL; i++) begin
         check("t5_tail", ccff_tail, prev_cfg[CL-1-i]);
         step(1, new_cfg[CL-1-i]);
         if (i == 0) check("t5_oe_off", pad_oe, 0);
      end
      step(0, 0);
      check("t5_done2", cfg_done, 1);

      // async reset mid-shift
      for (int i = 0; i < 17; i++) step(1, 1'($urandom));
      pReset = 1'b0;
      #1;
      check("t6_oe", pad_oe, 0);
      check("t6_done", cfg_done, 0);
      check("t6_err", cfg_err, 0);
      check("t6_tail", ccff_tail, 0);
      model_reset();
      #2 pReset = 1'b1;
      load(CL'(32'h2), CL);
      check("t6_redone", cfg_done, 1);
      check("t6_reoe", pad_oe, 8'h01);

      // randomized sessions with random IO traffic
      rand_io = 1;
      for (int s = 0; s < 40; s++) begin
         case ($urandom_range(0, 4))
            0:       nb = CL - 1;
            1:       nb = CL + 1;
            default: nb = CL;
         endcase
         load(CL'($urandom), nb);
         repeat ($urandom_range(3, 10)) step(0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
